imem_boot_loader: RTL and testbench

Upstream boot stage for `single_cycle_top`. It accepts a program as a byte stream over a valid/ready interface and assembles little-endian 32-bit words. It writes those words sequentially into the instruction memory write port and holds the core in reset until the whole image has landed. Its `core_rst_n` output drives the core's `rst_n`, replacing the fixed reset pulse plus `IMEM_INIT` file load in simulation and board bring-up.

---
 rtl/boot_pkg.sv | 15 +
 rtl/byte_packer.sv | 53 +++++
 rtl/imem_boot_loader.sv | 113 +++++++++++
 tb/tb_imem_boot_loader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the IMEM boot loader.
// The header and the payload words are both 4-byte little-endian fields.
package boot_pkg;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } boot_state_t;

  localparam int unsigned HDR_BYTES  = 4;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/byte_packer.sv
// 8->32 little-endian word assembler with lane counter and clear.
// word_next exposes the word being completed by the current byte for same-edge decisions.
module byte_packer
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        emit,
  output logic        last_byte,
  output logic [31:0] word_next,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam logic [1:0] LANE_LAST = 2'(WORD_BYTES - 1);

  logic [1:0]  lane;
  logic [23:0] acc;

  assign last_byte = byte_valid && (lane == LANE_LAST);
  assign word_next = {byte_data, acc};

  always_ff @(posedge clk) begin
    if (rst) begin
      lane       <= '0;
      acc        <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clr) begin
        lane <= '0;
      end else if (byte_valid) begin
        lane <= last_byte ? 2'd0 : lane + 2'd1;
        case (lane)
          2'd0:    acc[7:0]   <= byte_data;
          2'd1:    acc[15:8]  <= byte_data;
          2'd2:    acc[23:16] <= byte_data;
          default: ;
        endcase
        // Only payload words are published; the header is consumed via word_next.
        if (last_byte && emit) begin
          word_valid <= 1'b1;
          word       <= word_next;
        end
      end
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed program image into instruction memory and
// holds the core in reset until the final word has been committed.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   HDR   | collecting the 4-byte word count
//   LOAD  | packing payload bytes and writing one IMEM word per 4 bytes
//   DONE  | image written; core released one cycle after entry
//   ERR   | count larger than IMEM; core held in reset
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  boot_state_t state_q, state_d;

  logic            accept;
  logic            pk_clr;
  logic            pk_emit;
  logic            pk_last;
  logic [31:0]     pk_word_next;
  logic [ADDR_W:0] count_q;
  logic            hdr_zero;
  logic            hdr_over;
  logic            load_last;

  assign accept    = s_valid && s_ready;
  // Full 32-bit compare so huge counts cannot alias onto a legal size.
  assign hdr_zero  = (pk_word_next == 32'd0);
  assign hdr_over  = (pk_word_next > 32'(IMEM_DEPTH));
  assign load_last = ((words_loaded + (ADDR_W+1)'(1)) == count_q);

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (pk_clr),
    .byte_valid (accept),
    .byte_data  (s_data),
    .emit       (pk_emit),
    .last_byte  (pk_last),
    .word_next  (pk_word_next),
    .word_valid (imem_we),
    .word       (imem_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= HDR;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HDR: begin
        if (pk_last) begin
          if (hdr_zero)      state_d = DONE;
          else if (hdr_over) state_d = ERR;
          else               state_d = LOAD;
        end
      end
      LOAD: begin
        if (pk_last && load_last) state_d = DONE;
      end
      default: ;
    endcase
  end

  always_comb begin
    s_ready = (state_q == HDR) || (state_q == LOAD);
    pk_emit = (state_q == LOAD);
    pk_clr  = !s_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= '0;
      imem_waddr   <= '0;
      words_loaded <= '0;
      core_rst_n   <= 1'b0;
      busy         <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      if ((state_q == HDR) && pk_last) count_q <= pk_word_next[ADDR_W:0];
      // Address and count move on the same edge the packer raises imem_we.
      if ((state_q == LOAD) && pk_last) begin
        imem_waddr   <= words_loaded[ADDR_W-1:0];
        words_loaded <= words_loaded + (ADDR_W+1)'(1);
      end
      core_rst_n <= (state_q == DONE);
      busy       <= (state_d == HDR) || (state_d == LOAD);
      done       <= (state_d == DONE);
      err        <= (state_d == ERR);
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: table of image cases, random images against a
// rule-based model, and a mid-load reset sequence.
module tb_imem_boot_loader;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [31:0] word_q_t[$];

  typedef struct {
    string       name;
    logic [31:0] n_hdr;
    int unsigned kind;      // 0 smoke program, 1 incrementing, 2 random
    bit          throttle;
    bit          exp_done;
    bit          exp_err;
    int unsigned exp_loaded;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [7:0]    s_data;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          core_rst_n;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   words_loaded;

  always #5 clk = ~clk;

  imem_boot_loader #(.IMEM_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .core_rst_n   (core_rst_n),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;

  logic [31:0] tb_mem [DEPTH];
  int unsigned wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int unsigned wr_cyc_q[$];

  // Instruction memory stand-in plus a log of every write.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (imem_we) begin
      tb_mem[imem_waddr] <= imem_wdata;
      wr_addr_q.push_back(int'(imem_waddr));
      wr_data_q.push_back(imem_wdata);
      wr_cyc_q.push_back(cyc + 1);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic clear_log();
    for (int i = 0; i < DEPTH; i++) tb_mem[i] = '0;
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  // Offers bytes in order; stops early once the loader drops s_ready.
  task automatic stream(input byte_q_t bq, input bit throttle,
                        output int unsigned last_edge, output int unsigned n_acc);
    int unsigned idx;
    int unsigned guard;
    bit          acc;
    idx = 0; guard = 0; n_acc = 0; last_edge = 0;
    while (idx < bq.size() && guard < 4000) begin
      s_valid = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = s_valid ? bq[idx] : 8'($urandom);
      if (!s_ready) break;
      acc = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        n_acc++;
        last_edge = cyc;
      end
      guard++;
    end
    s_valid = 1'b0;
    if (guard >= 4000) chk("stream_timeout", 64'(guard), 64'd0);
  endtask

  function automatic byte_q_t image_bytes(input logic [31:0] n_hdr, input word_q_t words);
    byte_q_t bq;
    for (int b = 0; b < 4; b++) bq.push_back(n_hdr[8*b +: 8]);
    for (int i = 0; i < words.size(); i++)
      for (int b = 0; b < 4; b++) bq.push_back(words[i][8*b +: 8]);
    return bq;
  endfunction

  task automatic run_case(input string name, input logic [31:0] n_hdr, input word_q_t words,
                          input bit throttle, input bit exp_done, input bit exp_err,
                          input int unsigned exp_loaded);
    byte_q_t     bq;
    int unsigned last_edge, n_acc, exp_bytes, bad;
    do_reset();
    clear_log();
    bq = image_bytes(n_hdr, words);
    if (exp_err) repeat (4) bq.push_back(8'h5A);
    exp_bytes = exp_err ? 4 : bq.size();
    stream(bq, throttle, last_edge, n_acc);
    chk({name, "/bytes_accepted"}, 64'(n_acc), 64'(exp_bytes));
    if (exp_err) begin
      chk({name, "/err_t1"}, 64'(err), 64'd1);
      chk({name, "/busy_t1"}, 64'(busy), 64'd0);
      chk({name, "/s_ready_err"}, 64'(s_ready), 64'd0);
    end else begin
      chk({name, "/done_t1"}, 64'(done), 64'd1);
      chk({name, "/core_rst_n_t1"}, 64'(core_rst_n), 64'd0);
      @(posedge clk);
      #1;
      chk({name, "/core_rst_n_t2"}, 64'(core_rst_n), 64'd1);
      chk({name, "/s_ready_done"}, 64'(s_ready), 64'd0);
    end
    repeat (3) @(posedge clk);
    #1;
    chk({name, "/words_loaded"}, 64'(words_loaded), 64'(exp_loaded));
    chk({name, "/done"}, 64'(done), 64'(exp_done));
    chk({name, "/err"}, 64'(err), 64'(exp_err));
    chk({name, "/core_rst_n"}, 64'(core_rst_n), 64'(exp_done));
    chk({name, "/write_count"}, 64'(wr_addr_q.size()), 64'(exp_loaded));
    bad = 0;
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      if (i >= words.size()) bad++;
      else if (wr_addr_q[i] != i || wr_data_q[i] !== words[i] || tb_mem[i] !== words[i]) bad++;
    end
    if (exp_loaded > 0) begin
      chk({name, "/write_log"}, 64'(bad), 64'd0);
      chk({name, "/last_write_latency"}, 64'(wr_cyc_q[wr_cyc_q.size()-1]), 64'(last_edge + 1));
    end
    if (!throttle && exp_loaded > 1) begin
      bad = 0;
      for (int i = 1; i < wr_cyc_q.size(); i++)
        if (wr_cyc_q[i] - wr_cyc_q[i-1] != 4) bad++;
      chk({name, "/write_spacing"}, 64'(bad), 64'd0);
    end
  endtask

  vec_t        vecs[7];
  word_q_t     wq;
  word_q_t     smoke;
  logic [31:0] n;
  bit          thr;
  byte_q_t     bq;
  int unsigned le, na;

  initial begin
    smoke = '{32'h0050_0093, 32'h0070_0113, 32'h0020_81B3};
    vecs[0] = '{"smoke",     32'd3,           0, 1'b0, 1'b1, 1'b0, 3};
    vecs[1] = '{"empty",     32'd0,           1, 1'b0, 1'b1, 1'b0, 0};
    vecs[2] = '{"oversize",  32'd257,         1, 1'b0, 1'b0, 1'b1, 0};
    vecs[3] = '{"alias_big", 32'h0001_0001,   1, 1'b0, 1'b0, 1'b1, 0};
    vecs[4] = '{"throttled", 32'd3,           0, 1'b1, 1'b1, 1'b0, 3};
    vecs[5] = '{"single",    32'd1,           2, 1'b0, 1'b1, 1'b0, 1};
    vecs[6] = '{"full",      32'd256,         1, 1'b0, 1'b1, 1'b0, 256};

    do_reset();
    chk("rst/s_ready", 64'(s_ready), 64'd1);
    chk("rst/imem_we", 64'(imem_we), 64'd0);
    chk("rst/imem_waddr", 64'(imem_waddr), 64'd0);
    chk("rst/imem_wdata", 64'(imem_wdata), 64'd0);
    chk("rst/core_rst_n", 64'(core_rst_n), 64'd0);
    chk("rst/busy", 64'(busy), 64'd1);
    chk("rst/done", 64'(done), 64'd0);
    chk("rst/err", 64'(err), 64'd0);
    chk("rst/words_loaded", 64'(words_loaded), 64'd0);

    foreach (vecs[v]) begin
      wq.delete();
      if (!vecs[v].exp_err)
        for (int i = 0; i < int'(vecs[v].n_hdr); i++)
          case (vecs[v].kind)
            0:       wq.push_back(smoke[i]);
            1:       wq.push_back(32'h1000_0000 + 32'(i));
            default: wq.push_back($urandom);
          endcase
      run_case(vecs[v].name, vecs[v].n_hdr, wq, vecs[v].throttle,
               vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_loaded);
    end

    // Random images: a legal count loads exactly N words, anything above depth is an error.
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 3) == 0) n = 32'(DEPTH + 1) + 32'($urandom_range(0, 5000));
      else                          n = 32'($urandom_range(0, 24));
      thr = 1'($urandom_range(0, 1));
      wq.delete();
      if (n <= DEPTH) for (int i = 0; i < int'(n); i++) wq.push_back($urandom);
      run_case($sformatf("rand%0d", r), n, wq, thr, n <= DEPTH, n > DEPTH,
               (n <= DEPTH) ? n : 0);
    end

    // Reset after 6 payload bytes: first word already committed, second abandoned.
    do_reset();
    clear_log();
    bq = image_bytes(32'd3, smoke);
    bq = bq[0:9];
    stream(bq, 1'b0, le, na);
    chk("midrst/bytes_accepted", 64'(na), 64'd10);
    rst     = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hAA;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    s_valid = 1'b0;
    chk("midrst/s_ready", 64'(s_ready), 64'd1);
    chk("midrst/busy", 64'(busy), 64'd1);
    chk("midrst/words_loaded", 64'(words_loaded), 64'd0);
    chk("midrst/core_rst_n", 64'(core_rst_n), 64'd0);
    chk("midrst/done", 64'(done), 64'd0);
    chk("midrst/imem_we", 64'(imem_we), 64'd0);
    chk("midrst/imem0_kept", 64'(tb_mem[0]), 64'h0050_0093);
    chk("midrst/write_count", 64'(wr_addr_q.size()), 64'd1);
    run_case("reload", 32'd3, smoke, 1'b0, 1'b1, 1'b0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
